// File: rtl/mem_copy_engine_pkg.sv
// rtl/mem_copy_engine_pkg.sv - shared types and defaults for the word copy engine
package mem_copy_engine_pkg;

    localparam int WORD_W     = 32;
    localparam int ADDR_W_DEF = 32;
    localparam int LEN_W_DEF  = 24;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - read-then-write word copy engine driving one memory port
module mem_copy_engine
    import mem_copy_engine_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [LEN_W-1:0]  count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   src_ptr_q, src_ptr_d;
    logic [ADDR_W-1:0]   dst_ptr_q, dst_ptr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    count_q, count_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                aborted_q, aborted_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;

    // Next state and datapath: one word per READ -> CAPTURE -> WRITE round.
    always_comb begin
        state_d   = state_q;
        src_ptr_d = src_ptr_q;
        dst_ptr_d = dst_ptr_q;
        len_d     = len_q;
        count_d   = count_q;
        data_d    = data_q;
        aborted_d = aborted_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    src_ptr_d = src;
                    dst_ptr_d = dst;
                    len_d     = len;
                    count_d   = '0;
                    aborted_d = 1'b0;
                    state_d   = (len == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                // Memory returns the word addressed during READ in this cycle.
                data_d = mem_rdata;
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // The write in flight always lands; abort only stops the next word.
                count_d   = count_q + LEN_W'(1);
                src_ptr_d = src_ptr_q + ADDR_W'(1);
                dst_ptr_d = dst_ptr_q + ADDR_W'(1);
                if (abort) begin
                    aborted_d = 1'b1;
                end
                if (abort || (count_q + LEN_W'(1) == len_q)) begin
                    state_d = DONE;
                end else begin
                    state_d = READ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered outputs decoded from the state being entered.
    always_comb begin
        busy_d      = (state_d == READ) || (state_d == CAPTURE) || (state_d == WRITE);
        done_d      = (state_d == DONE);
        mem_we_d    = (state_d == WRITE);
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if ((state_d == READ) || (state_d == CAPTURE)) begin
            mem_addr_d = src_ptr_d;
        end else if (state_d == WRITE) begin
            mem_addr_d  = dst_ptr_d;
            mem_wdata_d = data_d;
        end
    end

    // State and output registers; reset overrides everything, so no write follows it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            len_q       <= '0;
            count_q     <= '0;
            data_q      <= '0;
            aborted_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            src_ptr_q   <= src_ptr_d;
            dst_ptr_q   <= dst_ptr_d;
            len_q       <= len_d;
            count_q     <= count_d;
            data_q      <= data_d;
            aborted_q   <= aborted_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign count     = count_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Word-granular copy engine that sits directly upstream of the simulation/block memory and drives one of its ports (addr/we/wdata/rdata).
- Copies LEN consecutive 32-bit words from SRC to DST on software or testbench command.
- Used to stage program images and relocate buffers without occupying the CPU data port.
- Operates strictly read-then-write per word, because the memory tri-states its read data while its write enable is high.

Parameters:
- ADDR_W, 32, width of word addresses (src, dst, mem_addr).
- LEN_W, 24, width of the length and count fields; the maximum transfer is 2^LEN_W-1 words.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- src  in  ADDR_W  first source word address; sampled with start.
- dst  in  ADDR_W  first destination word address; sampled with start.
- len  in  LEN_W  number of words; sampled with start.
- abort  in  1  requests early termination.
- busy  out  1  high in READ, CAPTURE and WRITE.
- done  out  1  one-cycle pulse when the transfer ends, normally or aborted.
- aborted  out  1  valid with done; 1 if the transfer was ended by abort.
- count  out  LEN_W  words written so far; holds its final value until the next start.
- mem_addr  out  ADDR_W  memory port address.
- mem_we  out  1  memory port write enable.
- mem_wdata  out  32  memory port write data.
- mem_rdata  in  32  memory port read data; valid one cycle after the read address is presented with mem_we=0.

Behaviour:
- Reset: state=IDLE. busy, done, aborted, mem_we are 0. count, mem_addr and mem_wdata are 0.
- Reset has priority over every other input. Reset asserted mid-transfer returns to IDLE on the next edge, and mem_we is 0 from that edge onward; no partial write occurs afterwards.
- FSM states: IDLE, READ, CAPTURE, WRITE, DONE.
- IDLE:
  - start=1 latches src, dst, len and clears count and aborted.
  - If len==0, go to DONE. Otherwise go to READ.
  - start while not IDLE is ignored entirely; there is no queuing.
- READ: mem_addr=src_ptr, mem_we=0. Go to CAPTURE.
- CAPTURE: mem_addr still holds src_ptr, mem_we=0. mem_rdata is registered into the data latch at the end of this cycle. Go to WRITE.
- WRITE:
  - mem_addr=dst_ptr, mem_we=1, mem_wdata=latched word.
  - At the end of the cycle: count+=1, src_ptr+=1, dst_ptr+=1.
  - If count+1==len, or abort is sampled high in this cycle, go to DONE. Otherwise go to READ.
- DONE: done=1 for exactly one cycle, busy=0, mem_we=0. Go to IDLE.
- Abort:
  - Sampled in READ or CAPTURE: go straight to DONE; the in-flight word is not written.
  - Sampled in WRITE: the current write completes, then DONE.
  - On every abort, aborted=1 in DONE.
  - abort in IDLE or DONE has no effect.
- Timing: for len=N>0, start sampled at edge k gives READ in cycle k+1 and done high in cycle k+3N+1. For len=0, done is high in cycle k+1 and no memory access occurs.
- Address arithmetic is modulo 2^ADDR_W; a wrap past the top address continues at 0.
- count never exceeds len.
- Overlap: copy is strictly ascending and word-at-a-time.
  - dst<src overlap produces a correct copy.
  - dst>src overlap propagates already-written words; this is defined behaviour, not an error.
- mem_we is 1 only in WRITE. It is never 1 in the same cycle that mem_rdata is sampled.

Decomposition:
- Shared package holds: the FSM state enum (IDLE, READ, CAPTURE, WRITE, DONE), the 32-bit word width constant, and the default ADDR_W/LEN_W.
- No sub-module is needed. The datapath (two pointers, counter, data latch) sits beside the FSM in one module.
- The bench instantiates the existing dual-port memory model; the engine drives port A and the bench preloads and checks through port B.

Test Plan:
- Basic copy: preload 0x1000..0x1003 = 0xA0..0xA3; start with src=0x1000, dst=0x2000, len=4 -> 0x2000..0x2003 = 0xA0..0xA3; done in cycle k+13; count=4; aborted=0.
- Zero length: len=0 -> done in cycle k+1; mem_we stays 0 throughout; count=0.
- Abort: len=8, abort asserted in the 3rd WRITE cycle -> exactly 3 words written (0x2000..0x2002); 0x2003 unchanged; count=3; aborted=1.
- Abort in CAPTURE of word 2 -> only 1 word written; count=1; aborted=1.
- Reset mid-transfer: len=8, reset asserted in a WRITE cycle -> that write completes; afterwards mem_we=0, state IDLE, count=0, no further writes.
- Start ignored and forward overlap: start pulsed while busy has no effect on the transfer. Separately, src=0x1000, dst=0x1001, len=3 with 0x1000=0x55 -> 0x1001..0x1003 all 0x55.
